sram_rw_pipe_ext: RTL and testbench

Parametrised single-port behavioural SRAM model with byte-granular write masking, configurable read latency, a read-valid/error sideband and deterministic output hold. It is the generalised successor of the fixed 256-bit × 512K memory model used by the L2 data/directory arrays. It lets any array geometry and macro latency be modelled in simulation without randomised garbage on idle cycles.

---
 rtl/sram_rw_pipe_ext.sv | 84 ++++++++
 tb/tb_sram_rw_pipe_ext.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_pipe_ext.sv
// Single-port behavioural SRAM with byte-lane write masking, a READ_LAT-deep read
// pipeline carrying {valid, err, data}, and output hold between results.
module sram_rw_pipe_ext #(
    parameter int ADDR_W   = 19,
    parameter int DEPTH    = 2 ** ADDR_W,
    parameter int DATA_W   = 256,
    parameter int MASK_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_rerr
);

    localparam int LANE_W = DATA_W / MASK_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Contents start at zero and are deliberately outside the reset domain.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic              rd_req;
    logic              wr_req;

    assign in_range = ({1'b0, RW0_addr} < DEPTH_LIM);
    assign idx      = RW0_addr[IDX_W-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;
    assign rd_req   = RW0_en && !RW0_wmode;
    assign wr_req   = RW0_en && RW0_wmode && in_range;

    always_ff @(posedge RW0_clk) begin
        if (RW0_rst_n && wr_req) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (RW0_wmask[i]) begin
                    mem[idx][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Result protocol: no back-pressure; rdata/rerr are meaningful only in a cycle
    // with rvalid=1. rdata holds its last result otherwise, rerr reads 0.
    logic              stage_valid [READ_LAT];
    logic              stage_err   [READ_LAT];
    logic [DATA_W-1:0] stage_data  [READ_LAT];

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            for (int k = 0; k < READ_LAT; k++) begin
                stage_valid[k] <= 1'b0;
                stage_err[k]   <= 1'b0;
                stage_data[k]  <= '0;
            end
        end else begin
            stage_valid[0] <= rd_req;
            stage_err[0]   <= rd_req && !in_range;
            if (rd_req) begin
                stage_data[0] <= rd_word;
            end
            for (int k = 1; k < READ_LAT; k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_err[k]   <= stage_valid[k-1] && stage_err[k-1];
                if (stage_valid[k-1]) begin
                    stage_data[k] <= stage_data[k-1];
                end
            end
        end
    end

    assign RW0_rvalid = stage_valid[READ_LAT-1];
    assign RW0_rerr   = stage_err[READ_LAT-1];
    assign RW0_rdata  = stage_data[READ_LAT-1];

endmodule

// File: tb/tb_sram_rw_pipe_ext.sv
// Directed bench for sram_rw_pipe_ext: three instances (latency 1, 3, 4) share one
// stimulus stream; each has its own expected queue and monitor.
module tb_sram_rw_pipe_ext;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int DATA_W = 256;
    localparam int MASK_W = 32;
    localparam int QW     = 32 + 1 + DATA_W;
    localparam int CW     = DATA_W + 2;

    // clock / reset
    logic clk;
    logic rst_n;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              wmode;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] rdata1, rdata3, rdata4;
    logic              rvalid1, rvalid3, rvalid4;
    logic              rerr1, rerr3, rerr4;

    sram_rw_pipe_ext #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .READ_LAT(1)) u_l1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata1), .RW0_rvalid(rvalid1), .RW0_rerr(rerr1));
    sram_rw_pipe_ext #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .READ_LAT(3)) u_l3 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata3), .RW0_rvalid(rvalid3), .RW0_rerr(rerr3));
    sram_rw_pipe_ext #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .MASK_W(MASK_W), .READ_LAT(4)) u_l4 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata4), .RW0_rvalid(rvalid4), .RW0_rerr(rerr4));

    // scoreboard: entries are {due_cycle, err, data}
    logic [QW-1:0] exp_q1[$];
    logic [QW-1:0] exp_q3[$];
    logic [QW-1:0] exp_q4[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [QW-1:0] e,
                             input logic err, input logic [DATA_W-1:0] data);
        logic [31:0]       due;
        logic              exp_err;
        logic [DATA_W-1:0] exp_data;
        {due, exp_err, exp_data} = e;
        checks++;
        if (data !== exp_data || err !== exp_err || cyc != int'(due)) begin
            failures++;
            $display("FAIL %s got data=%h err=%b cyc=%0d exp data=%h err=%b cyc=%0d",
                     name, data, err, cyc, exp_data, exp_err, due);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s rvalid with no expected result at cyc=%0d", name, cyc);
    endtask

    // monitors
    always @(negedge clk) begin
        if (rst_n && rvalid1) begin
            if (exp_q1.size() == 0) unexpected("lat1");
            else check_res("lat1", exp_q1.pop_front(), rerr1, rdata1);
        end
    end
    always @(negedge clk) begin
        if (rst_n && rvalid3) begin
            if (exp_q3.size() == 0) unexpected("lat3");
            else check_res("lat3", exp_q3.pop_front(), rerr3, rdata3);
        end
    end
    always @(negedge clk) begin
        if (rst_n && rvalid4) begin
            if (exp_q4.size() == 0) unexpected("lat4");
            else check_res("lat4", exp_q4.pop_front(), rerr4, rdata4);
        end
    end

    // driver tasks: inputs change 2 time units after the edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            en = 1'b0; wmode = 1'b0;
        end
    endtask

    task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        @(posedge clk); #2;
        en = 1'b1; wmode = 1'b1; addr = ADDR_W'(a); wdata = d; wmask = m;
    endtask

    // sel bit 0/1/2 selects which instances are expected to return this read
    task automatic do_read(input int a, input logic [DATA_W-1:0] d, input logic err, input logic [2:0] sel);
        @(posedge clk); #2;
        en = 1'b1; wmode = 1'b0; addr = ADDR_W'(a); wdata = '0; wmask = '0;
        if (sel[0]) exp_q1.push_back({32'(cyc + 1), err, d});
        if (sel[1]) exp_q3.push_back({32'(cyc + 3), err, d});
        if (sel[2]) exp_q4.push_back({32'(cyc + 4), err, d});
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_l1"}, {rvalid1, rerr1, rdata1}, '0);
        chk({tag, "_l3"}, {rvalid3, rerr3, rdata3}, '0);
        chk({tag, "_l4"}, {rvalid4, rerr4, rdata4}, '0);
    endtask

    localparam logic [DATA_W-1:0] ALL_AA = {32{8'hAA}};
    localparam logic [DATA_W-1:0] ALL_55 = {32{8'h55}};
    localparam logic [MASK_W-1:0] FULL   = '1;

    initial begin
        rst_n = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;

        // reset asserted mid-cycle, then idle
        #3 rst_n = 1'b0;
        #1 chk_cleared("rst_assert");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_cleared("rst_idle");
        end

        // masked write: lanes 0-3 get 0x55, the rest keep 0xAA
        do_write(5, ALL_AA, FULL);
        do_write(5, ALL_55, 32'h0000_000F);
        do_read(5, {{28{8'hAA}}, {4{8'h55}}}, 1'b0, 3'b111);
        idle(6);

        // back-to-back reads return in order, then output holds the last value
        for (int i = 0; i < 4; i++) do_write(i, DATA_W'(8'h10 + i), FULL);
        for (int i = 0; i < 4; i++) do_read(i, DATA_W'(8'h10 + i), 1'b0, 3'b111);
        idle(6);
        @(negedge clk);
        chk("hold_l1", {rvalid1, rerr1, rdata1}, {2'b00, DATA_W'(8'h13)});
        chk("hold_l3", {rvalid3, rerr3, rdata3}, {2'b00, DATA_W'(8'h13)});
        chk("hold_l4", {rvalid4, rerr4, rdata4}, {2'b00, DATA_W'(8'h13)});

        // snapshot ordering: read, overwrite, read again
        do_write(7, DATA_W'(1), FULL);
        do_read(7, DATA_W'(1), 1'b0, 3'b111);
        do_write(7, DATA_W'(2), FULL);
        do_read(7, DATA_W'(2), 1'b0, 3'b111);
        // read-after-write on consecutive edges, and a zero-mask write is a no-op
        do_write(8, DATA_W'(8'h88), FULL);
        do_read(8, DATA_W'(8'h88), 1'b0, 3'b111);
        do_write(3, '1, '0);
        do_read(3, DATA_W'(8'h13), 1'b0, 3'b111);
        idle(6);

        // out of range: write dropped, read returns zero with error
        do_write(999, DATA_W'(8'h99), FULL);
        do_write(1000, DATA_W'(8'hFF), FULL);
        do_read(1000, '0, 1'b1, 3'b111);
        do_read(999, DATA_W'(8'h99), 1'b0, 3'b111);
        do_read(1023, '0, 1'b1, 3'b111);
        do_read(0, DATA_W'(8'h10), 1'b0, 3'b111);
        idle(2);
        @(negedge clk);
        chk("err_clears_l1", {rvalid1, rerr1}, '0);
        idle(6);

        // reset mid-read: only the latency-1 result of the first read escapes
        do_read(1, DATA_W'(8'h11), 1'b0, 3'b001);
        do_read(2, DATA_W'(8'h12), 1'b0, 3'b000);
        @(posedge clk); #2;
        en = 1'b0; rst_n = 1'b0;
        #1 chk_cleared("rst_mid");
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(8);
        do_read(1, DATA_W'(8'h11), 1'b0, 3'b111);
        do_read(2, DATA_W'(8'h12), 1'b0, 3'b111);
        do_read(5, {{28{8'hAA}}, {4{8'h55}}}, 1'b0, 3'b111);
        idle(8);

        for (int i = 0; i < 50 && (exp_q1.size() + exp_q3.size() + exp_q4.size()) != 0; i++)
            @(negedge clk);
        checks++;
        if ((exp_q1.size() + exp_q3.size() + exp_q4.size()) != 0) begin
            failures++;
            $display("FAIL drain pending=%0d/%0d/%0d required=0/0/0",
                     exp_q1.size(), exp_q3.size(), exp_q4.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
